// File: rtl/video_timing_gen.sv
// video_timing_gen: 15 kHz raster timing with pixel CE, h/v counters and registered sync, blank and RGB
module video_timing_gen #(
  parameter int CE_DIV       = 2,
  parameter int H_TOTAL      = 384,
  parameter int H_ACTIVE     = 256,
  parameter int H_SYNC_START = 288,
  parameter int H_SYNC_WIDTH = 32,
  parameter int V_TOTAL      = 264,
  parameter int V_ACTIVE     = 224,
  parameter int V_SYNC_START = 240,
  parameter int V_SYNC_WIDTH = 8,
  parameter int HCNT_WIDTH   = 10,
  parameter int VCNT_WIDTH   = 9,
  parameter int COLOR_DEPTH  = 6
) (
  input  logic                   clk_sys,
  input  logic                   reset_n,
  input  logic [COLOR_DEPTH-1:0] r_in,
  input  logic [COLOR_DEPTH-1:0] g_in,
  input  logic [COLOR_DEPTH-1:0] b_in,
  output logic                   pix_ce,
  output logic [HCNT_WIDTH-1:0]  hcnt,
  output logic [VCNT_WIDTH-1:0]  vcnt,
  output logic                   line_start,
  output logic                   frame_start,
  output logic                   hs_out,
  output logic                   vs_out,
  output logic                   hblank,
  output logic                   vblank,
  output logic [COLOR_DEPTH-1:0] r_out,
  output logic [COLOR_DEPTH-1:0] g_out,
  output logic [COLOR_DEPTH-1:0] b_out
);
  localparam int DIV_W = CE_DIV > 1 ? $clog2(CE_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CE_DIV - 1);
  localparam logic [31:0] H_LAST = 32'(H_TOTAL - 1);
  localparam logic [31:0] V_LAST = 32'(V_TOTAL - 1);
  localparam logic [31:0] H_ACT  = 32'(H_ACTIVE);
  localparam logic [31:0] V_ACT  = 32'(V_ACTIVE);
  localparam logic [31:0] HS_BEG = 32'(H_SYNC_START);
  localparam logic [31:0] HS_END = 32'(H_SYNC_START + H_SYNC_WIDTH);
  localparam logic [31:0] VS_BEG = 32'(V_SYNC_START);
  localparam logic [31:0] VS_END = 32'(V_SYNC_START + V_SYNC_WIDTH);

  logic [DIV_W-1:0]       div_q, div_d;
  logic                   pix_ce_q, pix_ce_d;
  logic [HCNT_WIDTH-1:0]  hcnt_q, hcnt_d;
  logic [VCNT_WIDTH-1:0]  vcnt_q, vcnt_d;
  logic                   line_start_q, line_start_d;
  logic                   frame_start_q, frame_start_d;
  logic                   hs_q, hs_d, vs_q, vs_d;
  logic                   hblank_q, hblank_d, vblank_q, vblank_d;
  logic [COLOR_DEPTH-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic [31:0]            hx, vx;
  logic                   h_last, v_last, blank;

  always_comb begin
    hx            = 32'(hcnt_q);
    vx            = 32'(vcnt_q);
    h_last        = hx == H_LAST;
    v_last        = vx == V_LAST;
    blank         = hx >= H_ACT || vx >= V_ACT;
    div_d         = div_q == DIV_MAX ? '0 : div_q + DIV_W'(1);
    pix_ce_d      = div_q == DIV_MAX;
    hcnt_d        = !pix_ce_q ? hcnt_q : h_last ? '0 : hcnt_q + HCNT_WIDTH'(1);
    vcnt_d        = !(pix_ce_q && h_last) ? vcnt_q : v_last ? '0 : vcnt_q + VCNT_WIDTH'(1);
    line_start_d  = pix_ce_q && h_last;
    frame_start_d = line_start_d && v_last;
    hs_d          = pix_ce_q ? !(hx >= HS_BEG && hx < HS_END) : hs_q;
    vs_d          = pix_ce_q ? !(vx >= VS_BEG && vx < VS_END) : vs_q;
    hblank_d      = pix_ce_q ? hx >= H_ACT : hblank_q;
    vblank_d      = pix_ce_q ? vx >= V_ACT : vblank_q;
    r_d           = pix_ce_q ? (blank ? '0 : r_in) : r_q;
    g_d           = pix_ce_q ? (blank ? '0 : g_in) : g_q;
    b_d           = pix_ce_q ? (blank ? '0 : b_in) : b_q;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      div_q         <= '0;
      pix_ce_q      <= CE_DIV == 1;
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      hblank_q      <= 1'b1;
      vblank_q      <= 1'b1;
      r_q           <= '0;
      g_q           <= '0;
      b_q           <= '0;
    end else begin
      div_q         <= div_d;
      pix_ce_q      <= pix_ce_d;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      hblank_q      <= hblank_d;
      vblank_q      <= vblank_d;
      r_q           <= r_d;
      g_q           <= g_d;
      b_q           <= b_d;
    end
  end

  assign pix_ce      = pix_ce_q;
  assign hcnt        = hcnt_q;
  assign vcnt        = vcnt_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign hs_out      = hs_q;
  assign vs_out      = vs_q;
  assign hblank      = hblank_q;
  assign vblank      = vblank_q;
  assign r_out       = r_q;
  assign g_out       = g_q;
  assign b_out       = b_q;
endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: directed checks of raster timing, blanking, start pulses and async reset
module tb_video_timing_gen;
  localparam int LINE  = 768;
  localparam int FRAME = 24 * LINE;

  logic clk_sys = 1'b0;
  logic rst_n = 1'b0, rst_s_n = 1'b0;
  int cyc = 0, n_chk = 0, n_fail = 0;

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  logic       pix_ce, line_start, frame_start, hs_out, vs_out, hblank, vblank;
  logic [9:0] hcnt;
  logic [8:0] vcnt;
  logic [5:0] r_in, g_in, b_in, r_out, g_out, b_out;
  logic       s_pix_ce, s_line_start, s_frame_start, s_hs, s_vs, s_hblank, s_vblank;
  logic [9:0] s_hcnt;
  logic [8:0] s_vcnt;
  logic [5:0] s_r, s_g, s_b;

  assign r_in = hcnt[5:0];
  assign g_in = 6'h3F;
  assign b_in = vcnt[5:0];

  video_timing_gen #(.V_TOTAL(24), .V_ACTIVE(16), .V_SYNC_START(18), .V_SYNC_WIDTH(3)) u_dut (
    .clk_sys(clk_sys), .reset_n(rst_n), .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .pix_ce(pix_ce), .hcnt(hcnt), .vcnt(vcnt), .line_start(line_start), .frame_start(frame_start),
    .hs_out(hs_out), .vs_out(vs_out), .hblank(hblank), .vblank(vblank),
    .r_out(r_out), .g_out(g_out), .b_out(b_out));

  video_timing_gen #(.CE_DIV(1), .H_TOTAL(8), .H_ACTIVE(4), .H_SYNC_START(5), .H_SYNC_WIDTH(2),
                     .V_TOTAL(4), .V_ACTIVE(2), .V_SYNC_START(3), .V_SYNC_WIDTH(1)) u_small (
    .clk_sys(clk_sys), .reset_n(rst_s_n), .r_in(6'h15), .g_in(6'h2A), .b_in(6'h07),
    .pix_ce(s_pix_ce), .hcnt(s_hcnt), .vcnt(s_vcnt), .line_start(s_line_start), .frame_start(s_frame_start),
    .hs_out(s_hs), .vs_out(s_vs), .hblank(s_hblank), .vblank(s_vblank),
    .r_out(s_r), .g_out(s_g), .b_out(s_b));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk_sys);
  endtask

  task automatic wait_ev(input int sel, input int lim, input string tag, output int t);
    bit hit = 1'b0;
    t = -1;
    for (int i = 0; i < lim && !hit; i++) begin
      tick;
      hit = sel == 0 ? line_start : sel == 1 ? frame_start : (hcnt == 10'd100 && vcnt == 9'd10);
      if (hit) t = cyc;
    end
    chk(tag, 32'(hit), 1);
  endtask

  task automatic chk_reset_state(input string pfx);
    chk({pfx, "_hs"}, 32'(hs_out), 1);
    chk({pfx, "_vs"}, 32'(vs_out), 1);
    chk({pfx, "_hblank"}, 32'(hblank), 1);
    chk({pfx, "_vblank"}, 32'(vblank), 1);
    chk({pfx, "_rgb"}, 32'({r_out, g_out, b_out}), 0);
    chk({pfx, "_hcnt"}, 32'(hcnt), 0);
    chk({pfx, "_vcnt"}, 32'(vcnt), 0);
    chk({pfx, "_pix_ce"}, 32'(pix_ce), 0);
    chk({pfx, "_starts"}, 32'({line_start, frame_start}), 0);
  endtask

  initial begin
    int r, t0, t, f0, fall, rise, low, hi, cnt, err, prev, h, p, ls_first, ce_low, vs_low, fs_bad, fs_n;
    int fs_t[2];
    logic [17:0] exp_rgb;
    repeat (3) tick;
    chk_reset_state("rst");
    chk("small_rst_pix_ce", 32'(s_pix_ce), 1);

    rst_s_n = 1'b1;
    r = cyc;
    ls_first = -1; fall = -1; prev = 1; low = 0; cnt = 0; fs_n = 0; fs_bad = 0; ce_low = 0; vs_low = 0; err = 0;
    for (int i = 0; i < 80; i++) begin
      tick;
      t = cyc - r;
      p = t - 1;
      ce_low += 32'(!s_pix_ce);
      if (s_line_start) begin
        cnt++;
        if (ls_first < 0) ls_first = t;
      end
      if (s_frame_start) begin
        if (fs_n < 2) fs_t[fs_n] = t;
        fs_n++;
        fs_bad += 32'(!s_line_start);
      end
      if (prev == 1 && !s_hs && fall < 0) fall = t;
      prev = 32'(s_hs);
      low += 32'(!s_hs);
      vs_low += 32'(!s_vs);
      exp_rgb = (p % 8 < 4 && (p / 8) % 4 < 2) ? {6'h15, 6'h2A, 6'h07} : 18'd0;
      if ({s_r, s_g, s_b} !== exp_rgb) err++;
    end
    chk("small_pix_ce_low", 32'(ce_low), 0);
    chk("small_ls_first", 32'(ls_first), 8);
    chk("small_ls_count", 32'(cnt), 10);
    chk("small_fs_count", 32'(fs_n), 2);
    chk("small_fs_first", 32'(fs_t[0]), 32);
    chk("small_fs_period", 32'(fs_t[1] - fs_t[0]), 32);
    chk("small_fs_without_ls", 32'(fs_bad), 0);
    chk("small_hs_fall", 32'(fall), 6);
    chk("small_hs_low", 32'(low), 20);
    chk("small_vs_low", 32'(vs_low), 16);
    chk("small_rgb", 32'(err), 0);

    rst_n = 1'b1;
    r = cyc;
    tick;
    chk("ce_c1", 32'(pix_ce), 0);
    tick;
    chk("ce_c2", 32'(pix_ce), 1);
    chk("hcnt_c2", 32'(hcnt), 0);
    tick;
    chk("hcnt_c3", 32'(hcnt), 1);
    chk("starts_c3", 32'({line_start, frame_start}), 0);
    wait_ev(0, 2 * LINE, "wait_ls", t0);
    chk("ls_first", 32'(t0 - r), 769);

    fall = -1; prev = 1; low = 0; hi = 0; cnt = 0; err = 0;
    for (int k = 0; k < LINE; k++) begin
      if (k > 0) tick;
      if (prev == 1 && !hs_out && fall < 0) fall = k;
      prev = 32'(hs_out);
      low += 32'(!hs_out);
      hi += 32'(hblank);
      cnt += 32'(line_start);
      if (vblank) err++;
      if (k >= 2) begin
        h = (k - 2) / 2;
        exp_rgb = h < 256 ? {6'(h), 6'h3F, 6'd1} : 18'd0;
        if ({r_out, g_out, b_out} !== exp_rgb) err++;
      end
      if (k == 2 + 2 * 100) chk("r_px100", 32'(r_out), 36);
      if (k == 3 + 2 * 255) chk("r_px255", 32'({hblank, r_out}), 63);
      if (k == 2 + 2 * 256) chk("rgb_px256", 32'({hblank, r_out, g_out, b_out}), 32'h40000);
    end
    chk("hs_fall", 32'(fall), 578);
    chk("hs_low", 32'(low), 64);
    chk("hblank_cycles", 32'(hi), 256);
    chk("ls_per_line", 32'(cnt), 1);
    chk("line_rgb", 32'(err), 0);
    tick;
    chk("line_period", 32'({line_start, vcnt}), 32'h202);

    wait_ev(1, FRAME + 10, "wait_fs", f0);
    chk("fs_with_ls", 32'({line_start, hcnt, vcnt}), 32'h80000);
    fall = -1; rise = -1; prev = 1; low = 0; hi = 0; cnt = 0; err = 0;
    for (int k = 0; k < FRAME; k++) begin
      if (k > 0) tick;
      if (prev == 1 && !vs_out && fall < 0) fall = k;
      if (prev == 0 && vs_out && rise < 0) rise = k;
      prev = 32'(vs_out);
      low += 32'(!vs_out);
      hi += 32'(vblank);
      cnt += 32'(frame_start);
      if ((hblank || vblank) && {r_out, g_out, b_out} != 18'd0) err++;
    end
    chk("vs_fall", 32'(fall), 18 * LINE + 2);
    chk("vs_rise", 32'(rise), 21 * LINE + 2);
    chk("vs_low", 32'(low), 3 * LINE);
    chk("vblank_cycles", 32'(hi), 8 * LINE);
    chk("fs_per_frame", 32'(cnt), 1);
    chk("blank_rgb", 32'(err), 0);
    tick;
    chk("frame_period", 32'(frame_start), 1);

    wait_ev(2, FRAME, "wait_mid", t);
    chk("mid_rgb_live", 32'(r_out), 35);
    #2 rst_n = 1'b0;
    #1 chk_reset_state("mid");
    repeat (3) tick;
    chk("mid_held_hcnt", 32'(hcnt), 0);
    rst_n = 1'b1;
    r = cyc;
    wait_ev(0, 2 * LINE, "wait_ls_after", t);
    chk("ls_after_reset", 32'(t - r), 769);
    chk("vcnt_after_reset", 32'(vcnt), 1);
    wait_ev(1, FRAME + 10, "wait_fs_after", t);
    chk("fs_after_reset", 32'(t - r), FRAME + 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
